// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//
// Pipeline register bank for the D->E->M->W datapath. The E register takes
// the decoded D instruction, with hazard-control forwarding applied, or a
// bubble. The M and W registers drain every cycle without any stall or flush
// effect. Three event counters track stalls, flushes and retirements.
//
// Ports
//   clk, reset            : sole clock, synchronous active-high reset
//   D_*                   : decoded D-stage instruction (D_dst = 0 -> no write)
//   stall, flush          : hazard controller stall request, taken-branch squash
//   v1_mux/v2_mux,
//   v1_fw/v2_fw           : operand forwarding selects and forwarded values
//   E_result, M_result    : result values produced by the E and M stages
//   E_*                   : E-stage register contents
//   M_*, W_*              : M- and W-stage valid / destination / result
//   D_hold                : freeze PC and the F/D register (stall & ~flush)
//   stall_cnt, flush_cnt  : saturating 16-bit event counters
//   retire_cnt            : wrapping 32-bit count of cycles with W_valid
// ---------------------------------------------------------------------------
module pipe_stage_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_valid,
  input  logic [5:0]  D_opcode,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [4:0]  D_dst,
  input  logic        D_is_load,
  input  logic [31:0] D_v1,
  input  logic [31:0] D_v2,
  input  logic [31:0] D_imm,
  input  logic        stall,
  input  logic        v1_mux,
  input  logic        v2_mux,
  input  logic [31:0] v1_fw,
  input  logic [31:0] v2_fw,
  input  logic        flush,
  input  logic [31:0] E_result,
  input  logic [31:0] M_result,
  output logic        E_valid,
  output logic        E_is_load,
  output logic [5:0]  E_opcode,
  output logic [4:0]  E_rd,
  output logic [31:0] E_v1,
  output logic [31:0] E_v2,
  output logic [31:0] E_imm,
  output logic        M_valid,
  output logic        M_is_load,
  output logic [4:0]  M_rd,
  output logic [31:0] M_out,
  output logic        W_valid,
  output logic [4:0]  W_rd,
  output logic [31:0] W_out,
  output logic        D_hold,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [31:0] retire_cnt
);

  // Source register numbers and the M-stage result belong to the hazard
  // controller's view of the pipe. They pass through this block's interface
  // but nothing here consumes them.
  logic unused_inputs;
  assign unused_inputs = ^{D_rs, D_rt, M_result};

  logic accept;
  logic stall_event;

  // A flush overrides a stall, so D is never held when it is being squashed.
  // D_hold stays live during reset because the fetch side still needs it.
  assign D_hold      = stall & ~flush;
  assign stall_event = stall & ~flush;
  assign accept      = D_valid & ~stall & ~flush;

  // E register: capture D with forwarding applied, otherwise load a full
  // bubble. Every field of a bubble is zero, so E_rd can never match a
  // source register while E_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      E_valid   <= 1'b0;
      E_is_load <= 1'b0;
      E_opcode  <= '0;
      E_rd      <= '0;
      E_v1      <= '0;
      E_v2      <= '0;
      E_imm     <= '0;
    end else if (accept) begin
      E_valid   <= 1'b1;
      E_is_load <= D_is_load;
      E_opcode  <= D_opcode;
      E_rd      <= D_dst;
      E_v1      <= v1_mux ? v1_fw : D_v1;
      E_v2      <= v2_mux ? v2_fw : D_v2;
      E_imm     <= D_imm;
    end else begin
      E_valid   <= 1'b0;
      E_is_load <= 1'b0;
      E_opcode  <= '0;
      E_rd      <= '0;
      E_v1      <= '0;
      E_v2      <= '0;
      E_imm     <= '0;
    end
  end

  // M and W drain every cycle regardless of stall or flush. The destination
  // and load fields are qualified by valid so that invalid slots never look
  // like writers to the hazard controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      M_valid   <= 1'b0;
      M_is_load <= 1'b0;
      M_rd      <= '0;
      M_out     <= '0;
      W_valid   <= 1'b0;
      W_rd      <= '0;
      W_out     <= '0;
    end else begin
      M_valid   <= E_valid;
      M_is_load <= E_valid & E_is_load;
      M_rd      <= E_valid ? E_rd : 5'd0;
      M_out     <= E_result;
      W_valid   <= M_valid;
      W_rd      <= M_valid ? M_rd : 5'd0;
      W_out     <= M_out;
    end
  end

  // Event counters. Stall and flush counts saturate so that long runs do not
  // alias to small numbers. The retire count wraps like a free-running
  // counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (stall_event && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
      if (W_valid)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Scope: D->E->M->W pipeline register bank. Consumes the hazard controller's stall/forwarding outputs and produces its E/M destination and load inputs.

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs D_valid (1), D_opcode (6), D_rs (5), D_rt (5), D_dst (5, 0 = no write), D_is_load (1), D_v1 (32), D_v2 (32), D_imm (32): decoded D-stage instruction.
REQ-004 SHALL have inputs stall (1), v1_mux (1), v2_mux (1), v1_fw (32), v2_fw (32): hazard-control decisions for the D instruction.
REQ-005 SHALL have inputs flush (1), taken-branch squash of D, and E_result (32) / M_result (32), stage result values.
REQ-006 SHALL have outputs E_valid, E_is_load (1); E_opcode (6); E_rd (5); E_v1, E_v2, E_imm (32): E-stage register.
REQ-007 SHALL have outputs M_valid, M_is_load (1); M_rd (5); M_out (32); W_valid (1); W_rd (5); W_out (32).
REQ-008 SHALL have outputs D_hold (1), hold PC and F/D register; stall_cnt, flush_cnt (16 each); retire_cnt (32).

Function
REQ-009 SHALL assert D_hold combinationally = stall & ~flush.
REQ-010 SHALL load a bubble into E when reset=0 and any of flush=1, stall=1, D_valid=0. Bubble: E_valid=0, E_is_load=0, E_opcode=0, E_rd=0, E_v1=E_v2=E_imm=0.
REQ-011 Otherwise SHALL capture D into E: E_valid=1, E_opcode=D_opcode, E_is_load=D_is_load, E_rd=D_dst, E_imm=D_imm.
REQ-012 On capture, E_v1 SHALL = v1_mux ? v1_fw : D_v1, and E_v2 SHALL = v2_mux ? v2_fw : D_v2. Forwarded values are sampled in the same edge, with no extra latency.
REQ-013 SHALL clear E_rd to 0 whenever E_valid is 0, so a bubble never matches a source register.
REQ-014 M SHALL update every cycle, with no stall or flush effect: M_valid<=E_valid, M_is_load<=E_valid&E_is_load, M_rd<=E_valid?E_rd:0, M_out<=E_result.
REQ-015 W SHALL update every cycle: W_valid<=M_valid, W_rd<=M_valid?M_rd:0, W_out<=M_out.
REQ-016 Latency SHALL be exactly one cycle per stage: an instruction accepted at edge n is in M at n+1 and in W at n+2.
REQ-017 A stall of k consecutive cycles SHALL insert exactly k bubbles into E, while E/M/W continue draining.
REQ-018 flush SHALL take priority over stall: the D instruction is discarded, D_hold=0, flush_cnt counts, and stall_cnt does not count.
REQ-019 stall_cnt SHALL increment on each cycle with stall&~flush and saturate at 16'hFFFF.
REQ-020 flush_cnt SHALL increment on each cycle with flush=1 and saturate at 16'hFFFF.
REQ-021 retire_cnt SHALL increment on each cycle with W_valid=1 and wrap from 32'hFFFFFFFF to 0.
REQ-022 E_is_load, E_rd and M_rd SHALL be driven directly from registers, with no combinational path from stall or flush, so there is no loop through hazard control.

Reset
REQ-023 With reset=1 at an edge, all valid bits, rd fields, is_load bits, data registers and counters SHALL become 0.
REQ-024 During reset, D_hold SHALL still follow REQ-009, while registers and counters hold 0 regardless of stall or flush.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight instructions: W_valid=0 on the first cycle after reset, and retire_cnt does not count them.

Verification
REQ-026 Straight-line: accept D_dst=3, D_v1=5, v1_mux=0, no stall -> E_rd=3, E_v1=5 after 1 edge; M_rd=3 after 2; W_valid=1, W_rd=3 after 3; retire_cnt=1.
REQ-027 Forwarding: D_v1=1, v1_mux=1, v1_fw=32'hDEAD, D_v2=2, v2_mux=0 -> E_v1=32'hDEAD, E_v2=2.
REQ-028 Load-use: E holds load (E_is_load=1, E_rd=4); stall=1 for 1 cycle -> D_hold=1, next E_valid=0, E_rd=0, M_rd=4, M_is_load=1, stall_cnt=1; following cycle D captured.
REQ-029 Simultaneous flush+stall for 1 cycle -> D_hold=0, E bubble, flush_cnt=1, stall_cnt=0.
REQ-030 Saturation/wrap: stall held 65540 cycles -> stall_cnt=16'hFFFF. Preload retire_cnt near 32'hFFFFFFFF (via force) plus one retirement -> 0.
REQ-031 Reset mid-stream: three instructions in flight, reset for 1 edge -> all valid=0, rd=0, counters=0; no W_valid on the next cycle.
